// File: rtl/md_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: operation codes, FSM states, data width.
package md_pkg;
  localparam int DW = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_t;

  function automatic logic is_signed_op(md_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction
endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle; done pulses in the last iteration
// cycle with quotient/remainder presented combinationally as that iteration's result.
module div_iter
  import md_pkg::*;
#(
  parameter int W    = DW,
  parameter int ITER = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(ITER);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] cnt_q;
  logic          active_q;
  logic [W:0]    shifted, diff;
  logic          fits;

  // Quotient register doubles as the dividend shift register.
  always_comb begin
    shifted   = {rem_q, quo_q[W-1]};
    diff      = shifted - {1'b0, dvs_q};
    fits      = ~diff[W];
    remainder = fits ? diff[W-1:0] : shifted[W-1:0];
    quotient  = {quo_q[W-2:0], fits};
    done      = active_q && (cnt_q == CW'(ITER - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (kill) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      rem_q    <= '0;
      quo_q    <= dividend;
      dvs_q    <= divisor;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      rem_q <= remainder;
      quo_q <= quotient;
      cnt_q <= cnt_q + 1'b1;
      if (done) active_q <= 1'b0;
    end
  end
endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: 1-cycle registered multiply, iterative divide, MTHI/MTLO passthrough.
// Stalls the pipeline while busy; writes HI/LO once per operation; flush/reset abort with no write.
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int DW         = md_pkg::DW,
  parameter int DIV_CYCLES = md_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  md_op_t        md_op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic          ex_stall_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          hi_we_o,
  output logic          lo_we_o,
  output logic [DW-1:0] hi_wdata_o,
  output logic [DW-1:0] lo_wdata_o,
  output logic          busy_o
);
  md_state_t       state_q, state_d;
  logic [DW-1:0]   a_q, b_q, hi_q, lo_q;
  logic            sgn_q;
  logic            is_mul, is_div, op_sgn, accept;
  logic [DW-1:0]   a_mag, b_mag, quo, rem, div_hi, div_lo;
  logic [2*DW-1:0] ext_a, ext_b, prod;
  logic            div_done, div_kill, neg_q, neg_r;

  always_comb begin
    is_mul = (md_op_i == OP_MULT) || (md_op_i == OP_MULTU);
    is_div = (md_op_i == OP_DIV)  || (md_op_i == OP_DIVU);
    op_sgn = is_signed_op(md_op_i);
    accept = (state_q == S_IDLE) && !flush_i && (is_mul || is_div);
    a_mag  = (op_sgn && a_i[DW-1]) ? -a_i : a_i;
    b_mag  = (op_sgn && b_i[DW-1]) ? -b_i : b_i;
    div_kill = flush_i && (state_q == S_DIV);

    ext_a = sgn_q ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
    ext_b = sgn_q ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
    prod  = ext_a * ext_b;

    // Zero divisor bypasses the sign fix-up: LO all ones, HI the raw dividend.
    neg_q  = sgn_q && (a_q[DW-1] ^ b_q[DW-1]);
    neg_r  = sgn_q && a_q[DW-1];
    div_lo = (b_q == '0) ? '1  : (neg_q ? -quo : quo);
    div_hi = (b_q == '0) ? a_q : (neg_r ? -rem : rem);
  end

  div_iter #(.W(DW), .ITER(DIV_CYCLES)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_div),
    .kill      (div_kill),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    hi_we_o    = 1'b0;
    lo_we_o    = 1'b0;
    hi_wdata_o = '0;
    lo_wdata_o = '0;
    busy_o     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (!flush_i) begin
          if (is_mul || is_div) begin
            stall_o = 1'b1;
            state_d = is_mul ? S_MUL : S_DIV;
          end else if (md_op_i == OP_MTHI) begin
            hi_we_o    = 1'b1;
            hi_wdata_o = a_i;
          end else if (md_op_i == OP_MTLO) begin
            lo_we_o    = 1'b1;
            lo_wdata_o = a_i;
          end
        end
      end
      S_MUL: begin
        stall_o = !flush_i;
        state_d = flush_i ? S_IDLE : S_DONE;
      end
      S_DIV: begin
        stall_o = !flush_i;
        if (flush_i)       state_d = S_IDLE;
        else if (div_done) state_d = S_DONE;
      end
      S_DONE: begin
        hi_wdata_o = hi_q;
        lo_wdata_o = lo_q;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (!ex_stall_i) begin
          hi_we_o = 1'b1;
          lo_we_o = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      stall_o    = 1'b0;
      hi_we_o    = 1'b0;
      lo_we_o    = 1'b0;
      hi_wdata_o = '0;
      lo_wdata_o = '0;
      busy_o     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q   <= a_i;
        b_q   <= b_i;
        sgn_q <= op_sgn;
      end
      if (state_q == S_MUL) begin
        hi_q <= prod[2*DW-1:DW];
        lo_q <= prod[DW-1:0];
      end else if ((state_q == S_DIV) && div_done) begin
        hi_q <= div_hi;
        lo_q <= div_lo;
      end
    end
  end
endmodule
